// File: rtl/param_reg_file_if.sv
// Bus between the control block / write-back stage and param_reg_file.
// Carries the write port, the reservation (scoreboard) port and the two
// read ports with their busy flags and the pending count.
interface param_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_a;
    logic              busy_b;
    logic [ADDR_W:0]   pend_cnt;
    logic              any_pend;

    modport master (
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, busy_a, busy_b, pend_cnt, any_pend
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, busy_a, busy_b, pend_cnt, any_pend
    );
endinterface

// File: rtl/param_reg_file.sv
// Parametrised register file with a per-register pending (scoreboard) bit.
// One synchronous write port, two combinational read ports, an issue-time
// reservation port and a registered count of pending registers.
// Optional macro REGFILE_BYPASS_EN: write-through forwarding on both read
// ports (read data and busy follow a same-cycle write).
module param_reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 0
) (
    input logic            clk,
    input logic            rst,
    param_reg_file_if.slave bus
);
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend;
    logic [ADDR_W:0]     pend_cnt;

    logic                wr_ok;
    logic                rsv_ok;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] rsv_hit;
    logic                pend_at_wr;
    logic                pend_at_rsv;
    logic                cnt_inc;
    logic                cnt_dec;
    logic [DATA_W-1:0]   data_a;
    logic [DATA_W-1:0]   data_b;
    logic                busy_a_c;
    logic                busy_b_c;

    // Qualify write and reservation: in range, and not the hardwired zero register.
    always_comb begin
        wr_ok  = bus.wr_en && ({1'b0, bus.wr_addr} < NUM_REGS_L) &&
                 !(ZERO_REG != 0 && bus.wr_addr == '0);
        rsv_ok = bus.rsv_en && ({1'b0, bus.rsv_addr} < NUM_REGS_L) &&
                 !(ZERO_REG != 0 && bus.rsv_addr == '0);
    end

    // One-hot decode of write/reservation targets and current pending state at each.
    always_comb begin
        wr_hit      = '0;
        rsv_hit     = '0;
        pend_at_wr  = 1'b0;
        pend_at_rsv = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && bus.wr_addr == ADDR_W'(i)) begin
                wr_hit[i]  = 1'b1;
                pend_at_wr = pend[i];
            end
            if (rsv_ok && bus.rsv_addr == ADDR_W'(i)) begin
                rsv_hit[i]  = 1'b1;
                pend_at_rsv = pend[i];
            end
        end
    end

    // Incremental count: a set of a clear bit adds one; a write-back clearing a
    // pending bit subtracts one unless the same-cycle reservation re-owns it.
    always_comb begin
        cnt_inc = rsv_ok && !pend_at_rsv;
        cnt_dec = wr_ok && pend_at_wr && !(rsv_ok && bus.rsv_addr == bus.wr_addr);
    end

    // State update: reset clears everything; reservation wins over write-back clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    regs[i] <= bus.wr_data;
                end
                if (rsv_hit[i]) begin
                    pend[i] <= 1'b1;
                end else if (wr_hit[i]) begin
                    pend[i] <= 1'b0;
                end
            end
            pend_cnt <= pend_cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
        end
    end

    // Read mux: explicit compare per register so out-of-range addresses never alias.
    always_comb begin
        data_a   = '0;
        data_b   = '0;
        busy_a_c = 1'b0;
        busy_b_c = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((ZERO_REG == 0 || i != 0) && bus.rd_addr_a == ADDR_W'(i)) begin
                data_a   = regs[i];
                busy_a_c = pend[i];
            end
            if ((ZERO_REG == 0 || i != 0) && bus.rd_addr_b == ADDR_W'(i)) begin
                data_b   = regs[i];
                busy_b_c = pend[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && bus.wr_addr == bus.rd_addr_a) begin
            data_a   = bus.wr_data;
            busy_a_c = rsv_ok && bus.rsv_addr == bus.rd_addr_a;
        end
        if (wr_ok && bus.wr_addr == bus.rd_addr_b) begin
            data_b   = bus.wr_data;
            busy_b_c = rsv_ok && bus.rsv_addr == bus.rd_addr_b;
        end
`endif
    end

    assign bus.rd_data_a = data_a;
    assign bus.rd_data_b = data_b;
    assign bus.busy_a    = busy_a_c;
    assign bus.busy_b    = busy_b_c;
    assign bus.pend_cnt  = pend_cnt;
    assign bus.any_pend  = (pend_cnt != '0);

endmodule
